// File: rtl/cpu_arith_unit_if.sv
// cpu_arith_unit_if: operand/result bundle between the execute stage (master)
// and the integer arithmetic unit (slave).
interface cpu_arith_unit_if;
    logic [3:0]  i_alu_op;
    logic [31:0] i_op1;
    logic [31:0] i_op2;
    logic [31:0] o_alu_result;
    logic        o_alu_compare;

    logic        i_mul_start;
    logic        i_mul_signed;
    logic [31:0] i_mul_op1;
    logic [31:0] i_mul_op2;
    logic [63:0] o_mul_result;
    logic        o_mul_valid;

    logic        i_div_start;
    logic        i_div_signed;
    logic [31:0] i_div_numerator;
    logic [31:0] i_div_denominator;
    logic [31:0] o_div_quotient;
    logic [31:0] o_div_remainder;
    logic        o_div_busy;
    logic        o_div_valid;

    modport master (
        output i_alu_op, i_op1, i_op2,
        input  o_alu_result, o_alu_compare,
        output i_mul_start, i_mul_signed, i_mul_op1, i_mul_op2,
        input  o_mul_result, o_mul_valid,
        output i_div_start, i_div_signed, i_div_numerator, i_div_denominator,
        input  o_div_quotient, o_div_remainder, o_div_busy, o_div_valid
    );

    modport slave (
        input  i_alu_op, i_op1, i_op2,
        output o_alu_result, o_alu_compare,
        input  i_mul_start, i_mul_signed, i_mul_op1, i_mul_op2,
        output o_mul_result, o_mul_valid,
        input  i_div_start, i_div_signed, i_div_numerator, i_div_denominator,
        output o_div_quotient, o_div_remainder, o_div_busy, o_div_valid
    );
endinterface

// File: rtl/cpu_arith_unit.sv
// cpu_arith_unit: RV32 execute-stage integer arithmetic unit.
// Combinational ALU, fully pipelined 32x32->64 multiplier and a radix-2
// restoring divider with IDLE/RUN/FIX sequencing.
// Optional macro CPU_ARITH_DIV_EARLY_OUT_EN: a divide by zero or by one skips
// the iteration loop and finishes straight through FIX.
module cpu_arith_unit #(
    parameter int MUL_LATENCY = 3
) (
    input logic             i_clock,
    input logic             i_reset_n,
    cpu_arith_unit_if.slave bus
);
    localparam int DATA_W = 32;

    typedef enum logic [1:0] {
        DIV_IDLE,
        DIV_RUN,
        DIV_FIX
    } div_state_t;

    // Two's complement negation when en is set.
    function automatic logic [DATA_W-1:0] neg_if(input logic en, input logic [DATA_W-1:0] v);
        return en ? ((~v) + 32'd1) : v;
    endfunction

    // Absolute value for signed operands; 0x80000000 maps to itself, which is
    // the correct unsigned magnitude.
    function automatic logic [DATA_W-1:0] magnitude(input logic is_signed, input logic [DATA_W-1:0] v);
        return neg_if(is_signed & v[DATA_W-1], v);
    endfunction

    // ------------------------------------------------------------------ ALU
    logic signed [DATA_W-1:0] alu_a;
    logic signed [DATA_W-1:0] alu_b;
    logic        [4:0]        alu_shamt;
    logic        [DATA_W-1:0] alu_res;
    logic                     alu_cmp;

    assign alu_a     = bus.i_op1;
    assign alu_b     = bus.i_op2;
    assign alu_shamt = bus.i_op2[4:0];

    // Operation decode; compare codes fold the outcome into bit 0 of the result.
    always_comb begin
        alu_res = '0;
        alu_cmp = 1'b0;
        case (bus.i_alu_op)
            4'd0:  alu_res = bus.i_op1 + bus.i_op2;
            4'd1:  alu_res = bus.i_op1 - bus.i_op2;
            4'd2:  alu_res = bus.i_op1 & bus.i_op2;
            4'd3:  alu_res = bus.i_op1 | bus.i_op2;
            4'd4:  alu_res = bus.i_op1 ^ bus.i_op2;
            4'd5:  alu_res = bus.i_op1 << alu_shamt;
            4'd6:  alu_res = bus.i_op1 >> alu_shamt;
            4'd7:  alu_res = alu_a >>> alu_shamt;
            4'd8:  alu_cmp = (bus.i_op1 == bus.i_op2);
            4'd9:  alu_cmp = (bus.i_op1 != bus.i_op2);
            4'd10: alu_cmp = (alu_a < alu_b);
            4'd11: alu_cmp = (bus.i_op1 < bus.i_op2);
            4'd12: alu_cmp = (alu_a >= alu_b);
            4'd13: alu_cmp = (bus.i_op1 >= bus.i_op2);
            default: ;
        endcase
        if (bus.i_alu_op inside {[4'd8:4'd13]}) begin
            alu_res = {{(DATA_W-1){1'b0}}, alu_cmp};
        end
    end

    assign bus.o_alu_result  = alu_res;
    assign bus.o_alu_compare = alu_cmp;

    // ----------------------------------------------------------- multiplier
    logic signed [2*DATA_W-1:0] mul_a_ext;
    logic signed [2*DATA_W-1:0] mul_b_ext;
    logic signed [2*DATA_W-1:0] mul_prod;
    logic        [2*DATA_W-1:0] mul_prod_p [MUL_LATENCY];
    logic        [MUL_LATENCY-1:0] mul_vld_p;

    assign mul_a_ext = bus.i_mul_signed ? {{DATA_W{bus.i_mul_op1[DATA_W-1]}}, bus.i_mul_op1}
                                        : {{DATA_W{1'b0}}, bus.i_mul_op1};
    assign mul_b_ext = bus.i_mul_signed ? {{DATA_W{bus.i_mul_op2[DATA_W-1]}}, bus.i_mul_op2}
                                        : {{DATA_W{1'b0}}, bus.i_mul_op2};
    assign mul_prod  = mul_a_ext * mul_b_ext;

    // Stage p0: sample operands and form the full product on the start edge.
    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            mul_vld_p[0]  <= 1'b0;
            mul_prod_p[0] <= '0;
        end else begin
            mul_vld_p[0] <= bus.i_mul_start;
            if (bus.i_mul_start) begin
                mul_prod_p[0] <= mul_prod;
            end
        end
    end

    // Stages p1..: data moves only with its valid, so the last stage holds the
    // most recent product between strobes.
    for (genvar g = 1; g < MUL_LATENCY; g++) begin : g_mul_stage
        always_ff @(posedge i_clock or negedge i_reset_n) begin
            if (!i_reset_n) begin
                mul_vld_p[g]  <= 1'b0;
                mul_prod_p[g] <= '0;
            end else begin
                mul_vld_p[g] <= mul_vld_p[g-1];
                if (mul_vld_p[g-1]) begin
                    mul_prod_p[g] <= mul_prod_p[g-1];
                end
            end
        end
    end

    assign bus.o_mul_valid  = mul_vld_p[MUL_LATENCY-1];
    assign bus.o_mul_result = mul_prod_p[MUL_LATENCY-1];

    // -------------------------------------------------------------- divider
    div_state_t         div_state;
    div_state_t         div_state_nx;
    logic [4:0]         div_cnt;
    logic [DATA_W-1:0]  div_quo;
    logic [DATA_W-1:0]  div_rem;
    logic [DATA_W-1:0]  div_den;
    logic [DATA_W-1:0]  div_num;
    logic               div_neg_q;
    logic               div_neg_r;
    logic               div_by_zero;
    logic [DATA_W-1:0]  div_q_out;
    logic [DATA_W-1:0]  div_r_out;
    logic               div_vld;
    logic               div_early;
    logic [DATA_W:0]    div_shift;
    logic [DATA_W:0]    div_diff;
    logic               div_ge;

`ifdef CPU_ARITH_DIV_EARLY_OUT_EN
    // +1 in signed mode has the same bit pattern as unsigned 1.
    assign div_early = (bus.i_div_denominator == '0) || (bus.i_div_denominator == 32'd1);
`else
    assign div_early = 1'b0;
`endif

    // One restoring step: shift the next dividend bit into the partial
    // remainder and subtract the divisor if it fits.
    assign div_shift = {div_rem, div_quo[DATA_W-1]};
    assign div_diff  = div_shift - {1'b0, div_den};
    assign div_ge    = ~div_diff[DATA_W];

    // Divider state register.
    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            div_state <= DIV_IDLE;
        end else begin
            div_state <= div_state_nx;
        end
    end

    // Divider next-state: start leaves IDLE, 32 iterations in RUN, one FIX cycle.
    always_comb begin
        div_state_nx = div_state;
        case (div_state)
            DIV_IDLE: begin
                if (bus.i_div_start) begin
                    div_state_nx = div_early ? DIV_FIX : DIV_RUN;
                end
            end
            DIV_RUN: begin
                if (div_cnt == 5'd31) begin
                    div_state_nx = DIV_FIX;
                end
            end
            DIV_FIX:  div_state_nx = DIV_IDLE;
            default:  div_state_nx = DIV_IDLE;
        endcase
    end

    // Divider datapath: latch magnitudes, iterate, then apply signs and the
    // divide-by-zero override when publishing results.
    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            div_cnt     <= '0;
            div_quo     <= '0;
            div_rem     <= '0;
            div_den     <= '0;
            div_num     <= '0;
            div_neg_q   <= 1'b0;
            div_neg_r   <= 1'b0;
            div_by_zero <= 1'b0;
            div_q_out   <= '0;
            div_r_out   <= '0;
            div_vld     <= 1'b0;
        end else begin
            div_vld <= 1'b0;
            case (div_state)
                DIV_IDLE: begin
                    if (bus.i_div_start) begin
                        div_cnt     <= '0;
                        div_num     <= bus.i_div_numerator;
                        div_quo     <= magnitude(bus.i_div_signed, bus.i_div_numerator);
                        div_den     <= magnitude(bus.i_div_signed, bus.i_div_denominator);
                        div_rem     <= '0;
                        div_neg_q   <= bus.i_div_signed &
                                       (bus.i_div_numerator[DATA_W-1] ^ bus.i_div_denominator[DATA_W-1]);
                        div_neg_r   <= bus.i_div_signed & bus.i_div_numerator[DATA_W-1];
                        div_by_zero <= (bus.i_div_denominator == '0);
                    end
                end
                DIV_RUN: begin
                    div_cnt <= div_cnt + 5'd1;
                    div_rem <= div_ge ? div_diff[DATA_W-1:0] : div_shift[DATA_W-1:0];
                    div_quo <= {div_quo[DATA_W-2:0], div_ge};
                end
                DIV_FIX: begin
                    div_q_out <= div_by_zero ? '1 : neg_if(div_neg_q, div_quo);
                    div_r_out <= div_by_zero ? div_num : neg_if(div_neg_r, div_rem);
                    div_vld   <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign bus.o_div_quotient  = div_q_out;
    assign bus.o_div_remainder = div_r_out;
    assign bus.o_div_valid     = div_vld;
    assign bus.o_div_busy      = (div_state != DIV_IDLE);
endmodule

// File: tb/tb_cpu_arith_unit.sv
// tb_cpu_arith_unit: table-driven ALU/divider vectors, scoreboarded multiplier,
// and hand-written reset/busy sequences for cpu_arith_unit.
`timescale 1ns/1ps
module tb_cpu_arith_unit;
    localparam int MUL_LAT = 3;
`ifdef CPU_ARITH_DIV_EARLY_OUT_EN
    localparam int EO_LAT = 2;
`else
    localparam int EO_LAT = 34;
`endif
    localparam int DIV_LAT = 34;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   checks   = 0;
    int   failures = 0;
    int   cyc      = 0;

    cpu_arith_unit_if bus ();

    cpu_arith_unit #(.MUL_LATENCY(MUL_LAT)) dut (
        .i_clock   (clk),
        .i_reset_n (rst_n),
        .bus       (bus)
    );

    always #5 clk = ~clk;

    // Rising-edge counter, read only on falling edges.
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check64(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    // Reference multiply on 64-bit integers.
    function automatic logic [63:0] mul_model(input logic sgn, input logic [31:0] a, input logic [31:0] b);
        longint          sa, sb;
        longint unsigned ua, ub;
        if (sgn) begin
            sa = longint'(signed'(a));
            sb = longint'(signed'(b));
            return 64'(sa * sb);
        end
        ua = 64'(a);
        ub = 64'(b);
        return ua * ub;
    endfunction

    // Multiplier scoreboard: product and issue cycle pushed at issue time.
    typedef struct {
        logic [63:0] prod;
        int          cyc;
    } mul_exp_t;
    mul_exp_t mul_q[$];

    always @(negedge clk) begin
        mul_exp_t e;
        if (bus.o_mul_valid === 1'b1) begin
            if (mul_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL mul_unexpected_valid actual=1 required=0 cyc=%0d", cyc);
            end else begin
                e = mul_q.pop_front();
                check64("mul_result", bus.o_mul_result, e.prod);
                check64("mul_latency", 64'(cyc - e.cyc), 64'(MUL_LAT));
            end
        end
    end

    // Caller is on a falling edge; the following rising edge samples.
    task automatic mul_issue(input logic sgn, input logic [31:0] a, input logic [31:0] b,
                             input logic [63:0] exp);
        mul_exp_t e;
        bus.i_mul_start  = 1'b1;
        bus.i_mul_signed = sgn;
        bus.i_mul_op1    = a;
        bus.i_mul_op2    = b;
        e.prod = exp;
        e.cyc  = cyc;
        mul_q.push_back(e);
    endtask

    task automatic start_div(input logic sgn, input logic [31:0] num, input logic [31:0] den);
        bus.i_div_start       = 1'b1;
        bus.i_div_signed      = sgn;
        bus.i_div_numerator   = num;
        bus.i_div_denominator = den;
    endtask

    // Waits (bounded) for the valid strobe; busy must stay high until then.
    task automatic wait_div(input string name, input int c0, input logic [31:0] q,
                            input logic [31:0] r, input int lat);
        int   n = 0;
        logic busy_drop = 1'b0;
        while (bus.o_div_valid !== 1'b1 && n < 60) begin
            if (bus.o_div_busy !== 1'b1) busy_drop = 1'b1;
            @(negedge clk);
            n++;
        end
        check64({name, "_busy_held"}, 64'(busy_drop), 64'(0));
        if (bus.o_div_valid !== 1'b1) begin
            checks++;
            failures++;
            $display("FAIL %s_timeout actual=no_valid required=valid", name);
        end else begin
            check64({name, "_q"}, 64'(bus.o_div_quotient), 64'(q));
            check64({name, "_r"}, 64'(bus.o_div_remainder), 64'(r));
            check64({name, "_latency"}, 64'(cyc - c0), 64'(lat));
            check64({name, "_busy_at_valid"}, 64'(bus.o_div_busy), 64'(0));
        end
    endtask

    typedef struct {
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
        logic        cmp;
    } alu_vec_t;

    typedef struct {
        logic        sgn;
        logic [31:0] a;
        logic [31:0] b;
        logic [63:0] prod;
    } mul_vec_t;

    typedef struct {
        logic        sgn;
        logic [31:0] num;
        logic [31:0] den;
        logic [31:0] q;
        logic [31:0] r;
        int          lat;
    } div_vec_t;

    alu_vec_t alu_tab[$];
    mul_vec_t mul_tab[$];
    div_vec_t div_tab[$];

    initial begin
        int          c0;
        int          vcount;
        logic [31:0] ra, rb;
        logic        rs;

        alu_tab = '{
            '{4'd0,  32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 1'b0},
            '{4'd1,  32'h0000_0000, 32'h0000_0001, 32'hFFFF_FFFF, 1'b0},
            '{4'd2,  32'hF0F0_1234, 32'h0FF0_FFFF, 32'h00F0_1234, 1'b0},
            '{4'd3,  32'hF000_0000, 32'h0000_000F, 32'hF000_000F, 1'b0},
            '{4'd4,  32'hFFFF_0000, 32'h0F0F_0F0F, 32'hF0F0_0F0F, 1'b0},
            '{4'd5,  32'h0000_0001, 32'h0000_0021, 32'h0000_0002, 1'b0},
            '{4'd7,  32'h8000_0000, 32'h0000_0004, 32'hF800_0000, 1'b0},
            '{4'd6,  32'h8000_0000, 32'h0000_0024, 32'h0800_0000, 1'b0},
            '{4'd7,  32'h7FFF_FFFF, 32'h0000_001F, 32'h0000_0000, 1'b0},
            '{4'd8,  32'h0000_0005, 32'h0000_0005, 32'h0000_0001, 1'b1},
            '{4'd9,  32'h0000_0005, 32'h0000_0005, 32'h0000_0000, 1'b0},
            '{4'd10, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0001, 1'b1},
            '{4'd11, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 1'b0},
            '{4'd12, 32'h0000_0001, 32'hFFFF_FFFF, 32'h0000_0001, 1'b1},
            '{4'd13, 32'h0000_0001, 32'hFFFF_FFFF, 32'h0000_0000, 1'b0},
            '{4'd14, 32'h0000_0003, 32'h0000_0004, 32'h0000_0000, 1'b0},
            '{4'd15, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 1'b0}
        };
        mul_tab = '{
            '{1'b1, 32'hFFFF_FFFF, 32'h0000_0002, 64'hFFFF_FFFF_FFFF_FFFE},
            '{1'b0, 32'hFFFF_FFFF, 32'h0000_0002, 64'h0000_0001_FFFF_FFFE},
            '{1'b1, 32'h8000_0000, 32'h8000_0000, 64'h4000_0000_0000_0000},
            '{1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001},
            '{1'b1, 32'h0000_0007, 32'hFFFF_FFFD, 64'hFFFF_FFFF_FFFF_FFEB}
        };
        div_tab = '{
            '{1'b0, 32'd100,        32'd7,          32'd14,         32'd2,          DIV_LAT},
            '{1'b1, 32'hFFFF_FFF9, 32'd2,          32'hFFFF_FFFD, 32'hFFFF_FFFF, DIV_LAT},
            '{1'b0, 32'h0000_1234, 32'd0,          32'hFFFF_FFFF, 32'h0000_1234, EO_LAT},
            '{1'b1, 32'h0000_1234, 32'd0,          32'hFFFF_FFFF, 32'h0000_1234, EO_LAT},
            '{1'b1, 32'hFFFF_FFFB, 32'd0,          32'hFFFF_FFFF, 32'hFFFF_FFFB, EO_LAT},
            '{1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0,          DIV_LAT},
            '{1'b0, 32'hFFFF_FFFF, 32'd1,          32'hFFFF_FFFF, 32'd0,          EO_LAT},
            '{1'b1, 32'hFFFF_FFF9, 32'd1,          32'hFFFF_FFF9, 32'd0,          EO_LAT},
            '{1'b1, 32'd7,          32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'd1,          DIV_LAT},
            '{1'b0, 32'h8000_0000, 32'd3,          32'h2AAA_AAAA, 32'd2,          DIV_LAT}
        };

        bus.i_alu_op = '0;  bus.i_op1 = '0;  bus.i_op2 = '0;
        bus.i_mul_start = 1'b0;  bus.i_mul_signed = 1'b0;
        bus.i_mul_op1 = '0;  bus.i_mul_op2 = '0;
        bus.i_div_start = 1'b0;  bus.i_div_signed = 1'b0;
        bus.i_div_numerator = '0;  bus.i_div_denominator = '0;

        // Reset state.
        #12;
        check64("rst_mul_valid", 64'(bus.o_mul_valid), 64'(0));
        check64("rst_mul_result", bus.o_mul_result, 64'(0));
        check64("rst_div_busy", 64'(bus.o_div_busy), 64'(0));
        check64("rst_div_valid", 64'(bus.o_div_valid), 64'(0));
        check64("rst_div_q", 64'(bus.o_div_quotient), 64'(0));
        check64("rst_div_r", 64'(bus.o_div_remainder), 64'(0));
        @(negedge clk);
        rst_n = 1'b1;

        // ALU table.
        foreach (alu_tab[i]) begin
            bus.i_alu_op = alu_tab[i].op;
            bus.i_op1    = alu_tab[i].a;
            bus.i_op2    = alu_tab[i].b;
            #1;
            check64($sformatf("alu%0d_result", i), 64'(bus.o_alu_result), 64'(alu_tab[i].res));
            check64($sformatf("alu%0d_compare", i), 64'(bus.o_alu_compare), 64'(alu_tab[i].cmp));
        end

        // Multiplier: table vectors then random ones, all issued back to back.
        @(negedge clk);
        foreach (mul_tab[i]) begin
            mul_issue(mul_tab[i].sgn, mul_tab[i].a, mul_tab[i].b, mul_tab[i].prod);
            @(negedge clk);
        end
        for (int i = 0; i < 8; i++) begin
            ra = $urandom;
            rb = $urandom;
            rs = 1'($urandom_range(0, 1));
            mul_issue(rs, ra, rb, mul_model(rs, ra, rb));
            @(negedge clk);
        end
        bus.i_mul_start = 1'b0;
        for (int n = 0; n < 20 && mul_q.size() > 0; n++) @(negedge clk);
        check64("mul_drained", 64'(mul_q.size()), 64'(0));

        // Divider table.
        foreach (div_tab[i]) begin
            start_div(div_tab[i].sgn, div_tab[i].num, div_tab[i].den);
            c0 = cyc;
            @(negedge clk);
            bus.i_div_start = 1'b0;
            check64($sformatf("div%0d_busy_rise", i), 64'(bus.o_div_busy), 64'(1));
            wait_div($sformatf("div%0d", i), c0, div_tab[i].q, div_tab[i].r, div_tab[i].lat);
            @(negedge clk);
        end

        // Start while busy is ignored; start in the valid cycle is accepted.
        start_div(1'b0, 32'd100, 32'd7);
        c0 = cyc;
        @(negedge clk);
        bus.i_div_start = 1'b0;
        repeat (4) @(negedge clk);
        start_div(1'b0, 32'd1000, 32'd3);
        @(negedge clk);
        bus.i_div_start = 1'b0;
        wait_div("div_ignore", c0, 32'd14, 32'd2, DIV_LAT);
        start_div(1'b0, 32'd50, 32'd5);
        c0 = cyc;
        @(negedge clk);
        bus.i_div_start = 1'b0;
        wait_div("div_at_valid", c0, 32'd10, 32'd0, DIV_LAT);
        @(negedge clk);
        check64("div_idle_after", 64'(bus.o_div_busy), 64'(0));

        // Leave non-zero results behind before the reset test.
        start_div(1'b0, 32'd1000, 32'd3);
        c0 = cyc;
        @(negedge clk);
        bus.i_div_start = 1'b0;
        wait_div("div_pre_reset", c0, 32'd333, 32'd1, DIV_LAT);

        // Reset in the middle of RUN.
        @(negedge clk);
        start_div(1'b0, 32'd100, 32'd7);
        c0 = cyc;
        @(negedge clk);
        bus.i_div_start = 1'b0;
        repeat (9) @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check64("midrst_busy", 64'(bus.o_div_busy), 64'(0));
        check64("midrst_valid", 64'(bus.o_div_valid), 64'(0));
        check64("midrst_q", 64'(bus.o_div_quotient), 64'(0));
        check64("midrst_r", 64'(bus.o_div_remainder), 64'(0));
        check64("midrst_mul_result", bus.o_mul_result, 64'(0));
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        start_div(1'b0, 32'd200, 32'd9);
        c0 = cyc;
        @(negedge clk);
        bus.i_div_start = 1'b0;
        wait_div("div_post_reset", c0, 32'd22, 32'd2, DIV_LAT);

        // Reset with two products in flight discards them.
        @(negedge clk);
        mul_issue(1'b0, 32'd3, 32'd5, 64'd15);
        @(negedge clk);
        mul_issue(1'b0, 32'd7, 32'd9, 64'd63);
        @(negedge clk);
        bus.i_mul_start = 1'b0;
        #2;
        rst_n = 1'b0;
        mul_q.delete();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        vcount = 0;
        for (int n = 0; n < 8; n++) begin
            @(negedge clk);
            if (bus.o_mul_valid === 1'b1) vcount++;
        end
        check64("mulrst_no_valid", 64'(vcount), 64'(0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/cpu_arith_unit.md
Name: cpu_arith_unit

Overview:
- Integer arithmetic unit of the RV32 execute stage.
- Combines three engines behind one interface:
  - a combinational ALU (add/sub/logic/shift/compare);
  - a pipelined 32x32->64 multiplier (RV32M MUL/MULH/MULHU);
  - an iterative radix-2 divider (DIV/DIVU/REM/REMU).
- The execute stage selects operands and consumes results. The multiply and divide handshakes let it stall complex ops until their result is valid.

Parameters:
- MUL_LATENCY, 3: clock edges from operand sample to o_mul_valid; legal range 1..4.

Ports:
- i_clock  in  1  rising-edge clock
- i_reset_n  in  1  asynchronous, active-low reset
- i_alu_op  in  4  ALU operation code
- i_op1  in  32  ALU operand 1
- i_op2  in  32  ALU operand 2
- o_alu_result  out  32  ALU result (combinational)
- o_alu_compare  out  1  compare outcome (combinational)
- i_mul_start  in  1  sample multiplier operands this cycle
- i_mul_signed  in  1  1 = both operands signed, 0 = both unsigned
- i_mul_op1  in  32  multiplicand
- i_mul_op2  in  32  multiplier
- o_mul_result  out  64  full product
- o_mul_valid  out  1  product valid strobe
- i_div_start  in  1  start a division (ignored while busy)
- i_div_signed  in  1  1 = signed DIV/REM semantics
- i_div_numerator  in  32  dividend
- i_div_denominator  in  32  divisor
- o_div_quotient  out  32  quotient
- o_div_remainder  out  32  remainder
- o_div_busy  out  1  division in progress
- o_div_valid  out  1  quotient/remainder valid strobe

Behaviour:
- Reset (i_reset_n low, asynchronous):
  - all registered outputs (o_mul_result, o_mul_valid, o_div_*) go to 0;
  - pipeline and divider state clear; an in-flight multiply or divide is discarded;
  - the ALU outputs stay purely combinational.
- ALU op codes:
  - 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR;
  - 5 SLL, 6 SRL, 7 SRA; shift amount is i_op2[4:0];
  - 8 EQ, 9 NE, 10 LT (signed), 11 LTU, 12 GE (signed), 13 GEU;
  - 14, 15 reserved: result 0, compare 0.
- ALU results:
  - arithmetic wraps modulo 2^32;
  - for codes 8-13, o_alu_compare carries the outcome and o_alu_result = {31'b0, compare};
  - for codes 0-7, o_alu_compare = 0.
- Multiplier:
  - fully pipelined, one issue per cycle;
  - operands are sampled at the edge where i_mul_start = 1;
  - o_mul_valid is high for exactly one cycle, MUL_LATENCY edges later, with o_mul_result holding the product;
  - back-to-back starts give back-to-back valids in issue order;
  - o_mul_result holds its last value when not valid;
  - signed mode sign-extends both operands to 64 bits; unsigned mode zero-extends.
- Divider states:
  - IDLE: o_div_busy = 0. i_div_start = 1 latches the operands and signedness, takes magnitudes if signed, and goes to RUN. o_div_busy rises after that edge.
  - RUN: 32 restoring shift-subtract iterations, one per edge, then FIX.
  - FIX: applies signs (quotient negative if operand signs differ; remainder takes the dividend's sign), drives the quotient/remainder registers, pulses o_div_valid for one cycle, and returns to IDLE with busy low.
  - Total: o_div_valid is high on the 34th edge after the start edge.
  - i_div_start while busy is ignored; a start in the same cycle as valid is accepted.
- Divider special cases:
  - divide by zero: quotient 0xFFFFFFFF, remainder = dividend (both modes);
  - signed 0x80000000 / 0xFFFFFFFF: quotient 0x80000000, remainder 0;
  - quotient and remainder hold until the next valid.

Optional Feature:
- CPU_ARITH_DIV_EARLY_OUT_EN:
  - when defined, a divide by zero, or a denominator of 1 (unsigned mode, or +1 in signed mode), skips RUN;
  - results are the same as the normal path, with o_div_valid on the 2nd edge after the start edge.
  - When undefined, every division takes the full 34 edges.

Test Plan:
- ALU ops:
  - ADD 0xFFFFFFFF+1 -> 0;
  - SUB 0-1 -> 0xFFFFFFFF;
  - SRA 0x80000000 by 4 -> 0xF8000000;
  - SRL 0x80000000 by 36 -> 0x08000000 (shift uses low 5 bits);
  - LT 0xFFFFFFFF,1 -> compare 1, result 1; LTU with the same operands -> 0.
- Multiplier:
  - signed 0xFFFFFFFF*2 -> 0xFFFFFFFFFFFFFFFE; unsigned -> 0x00000001FFFFFFFE;
  - valid exactly 3 edges after start; three consecutive starts give three consecutive valids in order.
- Divider:
  - unsigned 100/7 -> q 14, r 2;
  - signed -7/2 -> q 0xFFFFFFFD, r 0xFFFFFFFF;
  - busy high for the whole operation; valid on the 34th edge;
  - a second start while busy is ignored.
- Divider corner cases:
  - x/0 with x = 0x1234 -> q 0xFFFFFFFF, r 0x1234;
  - signed 0x80000000/-1 -> q 0x80000000, r 0;
  - with CPU_ARITH_DIV_EARLY_OUT_EN defined, valid on the 2nd edge.
- Reset mid-operation: assert i_reset_n low during RUN (cycle 10) -> busy, valid and results go to 0 immediately; after release, a new division completes correctly.
- Reset during a multiply: assert reset with two products in flight -> no o_mul_valid after release.
